glb_core_strm_arbiter: RTL and testbench

Sequences access to the global buffer tile stream router's core-side injection port (`packet_sw2sr`). Up to `NUM_REQ` core requesters share that single port, for example the store DMA, the load DMA and the processor-side bridge. The block arbitrates round-robin with bounded burst locking, honours `clk_en` exactly as the router does, and drives a registered packet into the router every enabled cycle.

---
 rtl/glb_core_strm_arbiter_pkg.sv | 18 +
 rtl/glb_rr_arbiter.sv | 36 +++
 rtl/glb_core_strm_arbiter.sv | 141 ++++++++++++++
 tb/tb_glb_core_strm_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_core_strm_arbiter_pkg.sv
// Shared types and defaults for the global buffer core-side stream arbiter.
package glb_core_strm_arbiter_pkg;

    localparam int GLB_STRM_NUM_REQ     = 3;
    localparam int GLB_STRM_BURST_WIDTH = 4;

    typedef enum logic {
        STRM_IDLE = 1'b0,
        STRM_LOCK = 1'b1
    } strm_arb_state_e;

    typedef struct packed {
        logic        wr_en;
        logic [15:0] addr;
        logic [31:0] data;
    } packet_t;

endpackage

// File: rtl/glb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module glb_rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant_onehot,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Scan upward from ptr and keep the first valid requester.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand         = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!any && req[cand]) begin
                any                = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glb_core_strm_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of the router's
// core-side injection port. Output packet is registered; clk_en freezes all.
//   state     | meaning
//   STRM_IDLE | round-robin among all valid requesters
//   STRM_LOCK | only owner may send; ends on last beat, limit, or owner gap
module glb_core_strm_arbiter
    import glb_core_strm_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = GLB_STRM_NUM_REQ,
    parameter int BURST_WIDTH = GLB_STRM_BURST_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clk_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  packet_t [NUM_REQ-1:0]        req_packet,
    output logic [NUM_REQ-1:0]           req_ready,
    output packet_t                      packet_sw2sr,
    output logic                         sw2sr_active,
    output logic [$clog2(NUM_REQ)-1:0]   sw2sr_grant_id,
    input  logic [BURST_WIDTH-1:0]       cfg_max_burst
);
    localparam int IDX_W = $clog2(NUM_REQ);

    strm_arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    packet_t                pkt_q, pkt_d;
    logic                   active_q, active_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;

    logic [NUM_REQ-1:0]     arb_req;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [BURST_WIDTH-1:0] eff_limit;
    logic [BURST_WIDTH-1:0] beat_inc;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) return '0;
        return idx + IDX_W'(1);
    endfunction

    glb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req          (arb_req),
        .ptr          (rr_ptr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .any          (grant_any)
    );

    // Mask requests to the owner while locked; derive limit and saturating count.
    always_comb begin
        arb_req   = (state_q == STRM_LOCK) ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
        eff_limit = (cfg_max_burst == '0) ? BURST_WIDTH'(1) : cfg_max_burst;
        beat_inc  = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + BURST_WIDTH'(1);
        req_ready = grant_onehot & {NUM_REQ{clk_en & reset_n}};
    end

    // FSM, pointer and burst counter next-state.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (clk_en) begin
            case (state_q)
                STRM_IDLE: begin
                    if (grant_any) begin
                        if (!req_last[grant_idx] && (eff_limit > BURST_WIDTH'(1))) begin
                            state_d    = STRM_LOCK;
                            owner_d    = grant_idx;
                            beat_cnt_d = BURST_WIDTH'(1);
                        end else begin
                            rr_ptr_d = next_idx(grant_idx);
                        end
                    end
                end
                STRM_LOCK: begin
                    if (grant_any) begin
                        beat_cnt_d = beat_inc;
                        if (req_last[grant_idx] || (beat_inc >= eff_limit)) begin
                            state_d  = STRM_IDLE;
                            rr_ptr_d = next_idx(owner_q);
                        end
                    end else begin
                        // Owner went quiet: release the port so others get in.
                        state_d  = STRM_IDLE;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end
                default: state_d = STRM_IDLE;
            endcase
        end
    end

    // Output register next-state: accepted packet or zero; id holds when idle.
    always_comb begin
        pkt_d      = pkt_q;
        active_d   = active_q;
        grant_id_d = grant_id_q;
        if (clk_en) begin
            if (grant_any) begin
                pkt_d      = req_packet[grant_idx];
                active_d   = 1'b1;
                grant_id_d = grant_idx;
            end else begin
                pkt_d    = '0;
                active_d = 1'b0;
            end
        end
    end

    // State and output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= STRM_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            pkt_q      <= '0;
            active_q   <= 1'b0;
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_q      <= pkt_d;
            active_q   <= active_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign packet_sw2sr   = pkt_q;
    assign sw2sr_active   = active_q;
    assign sw2sr_grant_id = grant_id_q;

endmodule

// File: tb/tb_glb_core_strm_arbiter.sv
// Bench for glb_core_strm_arbiter: behavioural model checked every cycle plus
// hand-computed grant sequences per scenario.
module tb_glb_core_strm_arbiter;
    import glb_core_strm_arbiter_pkg::*;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           clk_en;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    packet_t [N-1:0] req_packet;
    logic [N-1:0]   req_ready;
    packet_t        packet_sw2sr;
    logic           sw2sr_active;
    logic [1:0]     sw2sr_grant_id;
    logic [3:0]     cfg_max_burst;

    always #5 clk = ~clk;

    glb_core_strm_arbiter #(.NUM_REQ(N), .BURST_WIDTH(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .clk_en         (clk_en),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_packet     (req_packet),
        .req_ready      (req_ready),
        .packet_sw2sr   (packet_sw2sr),
        .sw2sr_active   (sw2sr_active),
        .sw2sr_grant_id (sw2sr_grant_id),
        .cfg_max_burst  (cfg_max_burst)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic packet_t mkpkt(input int i, input int s);
        packet_t p;
        p.wr_en = s[0];
        p.addr  = {i[7:0], s[7:0]};
        p.data  = 32'hA000_0000 | (32'(i) << 16) | 32'(s);
        return p;
    endfunction

    // Requester sources: beats left, beats sent, start delay, one-cycle gap point.
    // lmode: 0 never last, 1 last on final beat, 2 last on every beat.
    int rem[N], sent[N], dly[N], gap_at[N], lmode[N];
    bit pausing[N];

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; sent[i] = 0; dly[i] = 0; gap_at[i] = -1; lmode[i] = 0; pausing[i] = 0;
        end
    endtask

    task automatic cfg_src(input int i, input int beats, input int mode, input int d, input int gap);
        rem[i] = beats; lmode[i] = mode; dly[i] = d; gap_at[i] = gap;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = (rem[i] > 0) && (dly[i] == 0) && !pausing[i];
            req_last[i]   = (lmode[i] == 2) || (lmode[i] == 1 && rem[i] == 1);
            req_packet[i] = mkpkt(i, sent[i]);
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                sent[i]++;
                rem[i]--;
                pausing[i] = (sent[i] == gap_at[i]);
            end else begin
                pausing[i] = 0;
            end
            if (reset_n && dly[i] > 0) dly[i]--;
        end
        drive();
    endtask

    // Reference model: port owner (-1 = free), pointer and beats in current burst.
    int      m_ptr, m_owner, m_beats;
    packet_t e_pkt;
    bit      e_act;
    int      e_id;
    bit      en_prev;
    int      log_q[$];

    initial begin
        m_ptr = 0; m_owner = -1; m_beats = 0; e_pkt = '0; e_act = 0; e_id = 0; en_prev = 0;
        forever begin
            int win;
            int lim;
            logic [N-1:0] e_ready;
            @(negedge clk);
            if (!reset_n) begin
                m_ptr = 0; m_owner = -1; m_beats = 0;
                e_pkt = '0; e_act = 0; e_id = 0; en_prev = 0;
                chk("rst_ready", 64'(req_ready), 64'(0));
                chk("rst_packet", 64'(packet_sw2sr), 64'(0));
                chk("rst_active", 64'(sw2sr_active), 64'(0));
                chk("rst_id", 64'(sw2sr_grant_id), 64'(0));
            end else begin
                win = -1;
                if (clk_en) begin
                    if (m_owner >= 0) begin
                        if (req_valid[m_owner]) win = m_owner;
                    end else begin
                        for (int k = 0; k < N; k++)
                            if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                    end
                end
                e_ready = (win >= 0) ? (N'(1) << win) : '0;
                chk("req_ready", 64'(req_ready), 64'(e_ready));
                chk("packet_sw2sr", 64'(packet_sw2sr), 64'(e_pkt));
                chk("sw2sr_active", 64'(sw2sr_active), 64'(e_act));
                chk("sw2sr_grant_id", 64'(sw2sr_grant_id), 64'(e_id));
                if (en_prev) log_q.push_back(sw2sr_active ? int'(sw2sr_grant_id) : -1);
                en_prev = clk_en;
                if (clk_en) begin
                    lim = (cfg_max_burst == 0) ? 1 : int'(cfg_max_burst);
                    if (win >= 0) begin
                        e_pkt = req_packet[win]; e_act = 1; e_id = win;
                        if (m_owner < 0) begin
                            if (!req_last[win] && lim > 1) begin
                                m_owner = win; m_beats = 1;
                            end else begin
                                m_ptr = (win + 1) % N;
                            end
                        end else begin
                            m_beats = (m_beats < 15) ? m_beats + 1 : 15;
                            if (req_last[win] || m_beats >= lim) begin
                                m_ptr = (m_owner + 1) % N; m_owner = -1;
                            end
                        end
                    end else begin
                        e_pkt = '0; e_act = 0;
                        if (m_owner >= 0) begin
                            m_ptr = (m_owner + 1) % N; m_owner = -1;
                        end
                    end
                end
            end
        end
    end

    // Compare the accepted-beat log (idle ends trimmed) against a literal order.
    task automatic check_seq(input string name, input int exp[$], input bit prefix);
        int t[$];
        t = log_q;
        while (t.size() > 0 && t[0] < 0) void'(t.pop_front());
        while (t.size() > 0 && t[t.size()-1] < 0) void'(t.pop_back());
        if (prefix) chk({name, "_len"}, 64'(t.size() >= exp.size()), 64'(1));
        else        chk({name, "_len"}, 64'(t.size()), 64'(exp.size()));
        for (int j = 0; j < exp.size(); j++)
            chk($sformatf("%s[%0d]", name, j), 64'(j < t.size() ? t[j] : -2), 64'(exp[j]));
    endtask

    task automatic begin_phase(input logic [3:0] c);
        reset_n = 1'b0;
        clk_en  = 1'b1;
        cfg_max_burst = c;
        clear_src();
    endtask

    task automatic release_and_run(input int n);
        drive();
        step();
        step();
        reset_n = 1'b1;
        log_q.delete();
        repeat (n) step();
    endtask

    initial begin
        int e[$];
        req_valid = '0; req_last = '0; req_packet = '0;

        // Fairness, cfg 1; all valid while in reset to check ready gating.
        begin_phase(4'd1);
        cfg_src(0, 3, 0, 0, -1); cfg_src(1, 3, 0, 0, -1); cfg_src(2, 3, 0, 0, -1);
        drive();
        #2;
        chk("init_ready", 64'(req_ready), 64'(0));
        chk("init_packet", 64'(packet_sw2sr), 64'(0));
        chk("init_active", 64'(sw2sr_active), 64'(0));
        release_and_run(14);
        e = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        check_seq("fair", e, 0);

        // Limit 0 behaves as 1.
        begin_phase(4'd0);
        cfg_src(0, 2, 0, 0, -1); cfg_src(1, 2, 0, 0, -1);
        release_and_run(8);
        e = '{0, 1, 0, 1};
        check_seq("cfg0", e, 0);

        // Burst limit 4.
        begin_phase(4'd4);
        cfg_src(1, 10, 0, 0, -1); cfg_src(2, 2, 2, 0, -1);
        release_and_run(20);
        e = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
        check_seq("burst", e, 0);

        // Early last.
        begin_phase(4'd8);
        cfg_src(0, 3, 1, 0, -1); cfg_src(1, 2, 1, 0, -1);
        release_and_run(10);
        e = '{0, 0, 0, 1, 1};
        check_seq("early_last", e, 0);

        // Lock break after two beats from requester 2.
        begin_phase(4'd8);
        cfg_src(2, 5, 1, 0, 2); cfg_src(0, 2, 1, 1, -1);
        release_and_run(14);
        e = '{2, 2, -1, 0, 0, 2, 2, 2};
        check_seq("lock_break", e, 0);

        // Clock-enable freeze mid-burst.
        begin_phase(4'd4);
        cfg_src(1, 6, 0, 0, -1); cfg_src(2, 1, 2, 0, -1);
        release_and_run(0);
        for (int t = 0; t < 20 && sent[1] < 2; t++) step();
        chk("freeze_wait", 64'(sent[1]), 64'(2));
        clk_en = 1'b0;
        repeat (5) step();
        chk("freeze_ready", 64'(req_ready), 64'(0));
        chk("freeze_packet", 64'(packet_sw2sr), 64'(mkpkt(1, 1)));
        chk("freeze_active", 64'(sw2sr_active), 64'(1));
        chk("freeze_id", 64'(sw2sr_grant_id), 64'(1));
        clk_en = 1'b1;
        repeat (12) step();
        e = '{1, 1, 1, 1, 2, 1, 1};
        check_seq("freeze", e, 0);

        // Mid-burst reset.
        begin_phase(4'd4);
        cfg_src(1, 8, 0, 0, -1); cfg_src(0, 4, 0, 3, -1); cfg_src(2, 4, 0, 3, -1);
        release_and_run(3);
        reset_n = 1'b0;
        #1;
        chk("mrst_packet", 64'(packet_sw2sr), 64'(0));
        chk("mrst_active", 64'(sw2sr_active), 64'(0));
        chk("mrst_id", 64'(sw2sr_grant_id), 64'(0));
        chk("mrst_ready", 64'(req_ready), 64'(0));
        step();
        step();
        reset_n = 1'b1;
        log_q.delete();
        repeat (10) step();
        e = '{0, 0, 0, 0, 1};
        check_seq("mid_reset", e, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
